// File: rtl/sbus_axi_bridge_if.sv
// rtl/sbus_axi_bridge_if.sv - sbus request/response interface
//
// Purpose: groups the sbus request fields and responder outputs into one bundle.
// Ports (signals):
//   en      request valid, held stable with all fields while stall=1
//   we      1 = write, 0 = read
//   size    0 = byte, 1 = half, 2 = word (3 treated as word)
//   addr    physical byte address
//   data_w  write data, byte lanes aligned to addr[1:0]
//   data_r  read data, valid in the cycle the read completes
//   stall   1 = request not yet complete
// Modports: master drives the request; slave is the responder (the bridge).

interface sbus_axi_bridge_if;
   logic        en;
   logic        we;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] data_w;
   logic [31:0] data_r;
   logic        stall;

   modport master (output en, we, size, addr, data_w, input data_r, stall);
   modport slave  (input en, we, size, addr, data_w, output data_r, stall);
endinterface

// File: rtl/sbus_axi_bridge.sv
// rtl/sbus_axi_bridge.sv - sbus responder turning each request into one single-beat AXI4 transfer
//
// Purpose: accepts one sbus request at a time and issues a single-beat AXI4 read or
// write for it, stalling the requester until the AXI response returns.
// Optional feature macro: SBUS_BRIDGE_ERR_EN adds o_bus_err, a one-cycle pulse in the
// completion cycle when the response is not OKAY or the response timed out.
// Parameters: AXI_ID (ARID/AWID value), TIMEOUT (response cycles allowed, 0 = unlimited).
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   sbus                               sbus slave modport (request in, data_r/stall out)
//   o_ar*, i_arready                   AR channel (arlen=0, arburst=INCR)
//   i_rdata/i_rresp/i_rlast/i_rvalid   R channel, o_rready
//   o_aw*, i_awready                   AW channel (awlen=0, awburst=INCR)
//   o_wdata/o_wstrb/o_wlast/o_wvalid   W channel, i_wready
//   i_bresp/i_bvalid, o_bready         B channel
//   o_bus_err                          error pulse (only with SBUS_BRIDGE_ERR_EN)

module sbus_axi_bridge #(
   parameter logic [3:0]  AXI_ID  = 4'd1,
   parameter int unsigned TIMEOUT = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   sbus_axi_bridge_if.slave   sbus,
   // AR / R
   output logic [3:0]         o_arid,
   output logic [31:0]        o_araddr,
   output logic [2:0]         o_arsize,
   output logic [7:0]         o_arlen,
   output logic [1:0]         o_arburst,
   output logic               o_arvalid,
   input  logic               i_arready,
   input  logic [31:0]        i_rdata,
   input  logic [1:0]         i_rresp,
   input  logic               i_rlast,
   input  logic               i_rvalid,
   output logic               o_rready,
   // AW / W / B
   output logic [3:0]         o_awid,
   output logic [31:0]        o_awaddr,
   output logic [2:0]         o_awsize,
   output logic [7:0]         o_awlen,
   output logic [1:0]         o_awburst,
   output logic               o_awvalid,
   input  logic               i_awready,
   output logic [31:0]        o_wdata,
   output logic [3:0]         o_wstrb,
   output logic               o_wlast,
   output logic               o_wvalid,
   input  logic               i_wready,
   input  logic [1:0]         i_bresp,
   input  logic               i_bvalid,
   output logic               o_bready
`ifdef SBUS_BRIDGE_ERR_EN
   ,
   output logic               o_bus_err
`endif
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_AR   = 3'd1;
   localparam logic [2:0] S_RD_R    = 3'd2;
   localparam logic [2:0] S_WR_AW_W = 3'd3;
   localparam logic [2:0] S_WR_B    = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0]  r_state;
   logic [31:0] r_addr;
   logic [31:0] r_data_w;
   logic [31:0] r_data_r;
   logic [1:0]  r_size;
   logic [31:0] r_cnt;
   logic        r_aw_done;
   logic        r_w_done;
   logic        r_drain_r;
   logic        r_drain_b;

   logic [1:0]  w_size;
   logic [31:0] w_addr_al;
   logic [3:0]  w_strb;
   logic        w_ar_hs;
   logic        w_aw_hs;
   logic        w_w_hs;
   logic        w_timeout;

   // Illegal size 3 behaves exactly like a word access.
   assign w_size = (r_size == 2'd3) ? 2'd2 : r_size;

   always_comb begin
      w_addr_al = r_addr;
      w_strb    = 4'hF;
      case (w_size)
         2'd0: begin
            w_addr_al = r_addr;
            w_strb    = 4'b0001 << r_addr[1:0];
         end
         2'd1: begin
            w_addr_al = {r_addr[31:1], 1'b0};
            w_strb    = 4'b0011 << {r_addr[1], 1'b0};
         end
         default: begin
            w_addr_al = {r_addr[31:2], 2'b00};
            w_strb    = 4'hF;
         end
      endcase
   end

   assign sbus.stall = sbus.en & (r_state != S_DONE);
   assign sbus.data_r = r_data_r;

   assign o_arid    = AXI_ID;
   assign o_araddr  = w_addr_al;
   assign o_arsize  = {1'b0, w_size};
   assign o_arlen   = 8'd0;
   assign o_arburst = 2'b01;
   assign o_arvalid = (r_state == S_RD_AR);
   // After a timeout the late beat is still owed to the interconnect; swallow it in IDLE.
   assign o_rready  = (r_state == S_RD_R) | ((r_state == S_IDLE) & r_drain_r);

   assign o_awid    = AXI_ID;
   assign o_awaddr  = w_addr_al;
   assign o_awsize  = {1'b0, w_size};
   assign o_awlen   = 8'd0;
   assign o_awburst = 2'b01;
   assign o_awvalid = (r_state == S_WR_AW_W) & ~r_aw_done;
   assign o_wdata   = r_data_w;
   assign o_wstrb   = w_strb;
   assign o_wlast   = 1'b1;
   assign o_wvalid  = (r_state == S_WR_AW_W) & ~r_w_done;
   assign o_bready  = (r_state == S_WR_B) | ((r_state == S_IDLE) & r_drain_b);

   assign w_ar_hs = o_arvalid & i_arready;
   assign w_aw_hs = o_awvalid & i_awready;
   assign w_w_hs  = o_wvalid & i_wready;

   generate
      if (TIMEOUT > 0) begin : g_timeout
         assign w_timeout = ((r_state == S_RD_R) | (r_state == S_WR_B)) &
                            (r_cnt == 32'(TIMEOUT - 1));
      end else begin : g_no_timeout
         assign w_timeout = 1'b0;
      end
   endgenerate

`ifdef SBUS_BRIDGE_ERR_EN
   logic r_err;
   assign o_bus_err = (r_state == S_DONE) & r_err;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_data_w  <= '0;
         r_data_r  <= '0;
         r_size    <= '0;
         r_cnt     <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_drain_r <= 1'b0;
         r_drain_b <= 1'b0;
`ifdef SBUS_BRIDGE_ERR_EN
         r_err     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (sbus.en) begin
                  r_addr    <= sbus.addr;
                  r_size    <= sbus.size;
                  r_data_w  <= sbus.data_w;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_state   <= sbus.we ? S_WR_AW_W : S_RD_AR;
               end
            end
            S_RD_AR: begin
               if (w_ar_hs) begin
                  r_cnt   <= '0;
                  r_state <= S_RD_R;
               end
            end
            S_RD_R: begin
               // A beat arriving in the expiry cycle wins over the timeout.
               if (i_rvalid) begin
                  r_data_r <= i_rdata;
`ifdef SBUS_BRIDGE_ERR_EN
                  r_err    <= (i_rresp != 2'b00);
`endif
                  r_state  <= S_DONE;
               end else if (w_timeout) begin
                  r_data_r  <= 32'hFFFF_FFFF;
                  r_drain_r <= 1'b1;
`ifdef SBUS_BRIDGE_ERR_EN
                  r_err     <= 1'b1;
`endif
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            S_WR_AW_W: begin
               if (w_aw_hs) r_aw_done <= 1'b1;
               if (w_w_hs)  r_w_done  <= 1'b1;
               if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                  r_cnt   <= '0;
                  r_state <= S_WR_B;
               end
            end
            S_WR_B: begin
               if (i_bvalid) begin
`ifdef SBUS_BRIDGE_ERR_EN
                  r_err   <= (i_bresp != 2'b00);
`endif
                  r_state <= S_DONE;
               end else if (w_timeout) begin
                  r_drain_b <= 1'b1;
`ifdef SBUS_BRIDGE_ERR_EN
                  r_err     <= 1'b1;
`endif
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            S_DONE: begin
`ifdef SBUS_BRIDGE_ERR_EN
               r_err   <= 1'b0;
`endif
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         if ((r_state == S_IDLE) & r_drain_r & i_rvalid) r_drain_r <= 1'b0;
         if ((r_state == S_IDLE) & r_drain_b & i_bvalid) r_drain_b <= 1'b0;
      end
   end

endmodule
